uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Two-requester round-robin arbiter in front of a single UART transmitter.
//   A grant captures the winner's byte onto uart_din, strobes uart_start and
//   acks the winner for one cycle.  The arbiter then waits for the UART to go
//   busy, and then for it to go idle again.
//   If busy never rises within TIMEOUT cycles, the launch is abandoned and err
//   pulses.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   req0/data0/ack0       requester 0: request, byte, capture pulse
//   req1/data1/ack1       requester 1: request, byte, capture pulse
//   uart_din, uart_start  byte and one-cycle launch strobe to the UART
//   uart_busy             UART busy flag
//   grant_id              owner of the current or most recent frame
//   done, err             one-cycle pulses: frame finished / launch timed out
//   idle                  registered "state == IDLE"
module uart_tx_arb #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] uart_din,
    output logic       uart_start,
    input  logic       uart_busy,
    output logic       grant_id,
    output logic       done,
    output logic       err,
    output logic       idle
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state;
    logic       last;
    logic [7:0] cnt;
    logic       pick;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) pick = ~last;
        else              pick = req1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            grant_id   <= 1'b0;
            uart_din   <= 8'h00;
            uart_start <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            idle       <= 1'b1;
            cnt        <= 8'h00;
        end else begin
            uart_start <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    // The done/err pulse cycle is already IDLE; hold off the
                    // next grant for that one cycle.
                    if (!done && !err && (req0 || req1)) begin
                        uart_din   <= pick ? data1 : data0;
                        uart_start <= 1'b1;
                        ack0       <= ~pick;
                        ack1       <= pick;
                        grant_id   <= pick;
                        last       <= pick;
                        cnt        <= 8'h00;
                        state      <= WAIT_BUSY;
                        idle       <= 1'b0;
                    end
                end
                WAIT_BUSY: begin
                    // busy wins over timeout when both happen together
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == TMO) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        idle  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule
